// File: rtl/snn_delay_layer.sv
// -----------------------------------------------------------------------------
// snn_delay_layer
//
// One layer of leaky integrate-and-fire neurons fed by M spike inputs through
// N*M synapses.  Every synapse carries a signed weight and an axonal delay of
// 0..D timesteps (D = 2^DW-1).  A timestep happens on any cycle where
// enable=1 and step=1; its results appear on the following cycle together
// with a one-cycle step_done pulse.  DW must be at least 2.
//
// Optional build macro: SNN_MEMBRANE_OUT_EN
//   defined   -> membrane_potential_out shows the registered membranes
//   undefined -> membrane_potential_out is tied to zero (port kept)
//
// Ports
//   clk                    : clock, all state updates on the rising edge
//   reset_n                : asynchronous active-low reset
//   enable, step           : timestep qualifier pair
//   input_spikes [M]       : spikes presented for the current timestep
//   weights [N*M*WW]       : synapse (n,m) weight at [(n*M+m)*WW +: WW]
//   delays  [N*M*DW]       : synapse (n,m) delay  at [(n*M+m)*DW +: DW]
//   threshold, decay,
//   refractory_period      : shared neuron parameters (MPW bits each)
//   output_spikes [N]      : registered neuron spikes
//   step_done              : pulse on the cycle after each timestep
//   membrane_potential_out : neuron n membrane at [n*MPW +: MPW]
// -----------------------------------------------------------------------------
module snn_delay_layer #(
   parameter int M   = 24,
   parameter int N   = 8,
   parameter int WW  = 2,
   parameter int MPW = 6,
   parameter int DW  = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               step,
   input  logic [M-1:0]       input_spikes,
   input  logic [N*M*WW-1:0]  weights,
   input  logic [N*M*DW-1:0]  delays,
   input  logic [MPW-1:0]     threshold,
   input  logic [MPW-1:0]     decay,
   input  logic [MPW-1:0]     refractory_period,
   output logic [N-1:0]       output_spikes,
   output logic               step_done,
   output logic [N*MPW-1:0]   membrane_potential_out
);

   localparam int D  = (1 << DW) - 1;
   localparam int SW = WW + $clog2(M) + 1;   // synaptic sum width, cannot overflow
   localparam int VW = SW + MPW + 1;         // membrane + sum before clamping

   localparam logic signed [VW-1:0] V_ZERO = {VW{1'b0}};
   localparam logic signed [VW-1:0] V_MAX  = {{(VW-MPW){1'b0}}, {MPW{1'b1}}};

   logic [D-1:0]          hist_r   [M];
   logic [MPW-1:0]        mem_r    [N];
   logic [MPW-1:0]        refr_r   [N];
   logic [N-1:0]          spk_r;
   logic                  done_r;

   logic                  timestep_s;
   logic [DW-1:0]         dly_s    [N][M];
   logic signed [WW-1:0]  w_s      [N][M];
   logic                  del_spk_s[N][M];
   logic signed [SW-1:0]  sum_s    [N];
   logic signed [VW-1:0]  v_s      [N];
   logic [MPW-1:0]        vsat_s   [N];
   logic [MPW-1:0]        mem_nxt_s[N];
   logic [MPW-1:0]        refr_nxt_s[N];
   logic [N-1:0]          spk_nxt_s;

   assign timestep_s = enable & step;

   // Pick the spike each synapse sees: live input for delay 0, else the
   // history bit recorded `delay` timesteps ago (history before this shift).
   always_comb begin
      for (int n = 0; n < N; n++) begin
         for (int m = 0; m < M; m++) begin
            dly_s[n][m] = delays[(n*M+m)*DW +: DW];
            w_s[n][m]   = weights[(n*M+m)*WW +: WW];
            if (dly_s[n][m] == {DW{1'b0}}) begin
               del_spk_s[n][m] = input_spikes[m];
            end else begin
               del_spk_s[n][m] = hist_r[m][dly_s[n][m] - DW'(1'b1)];
            end
         end
      end
   end

   // Signed accumulation of sign-extended weights over active synapses.
   always_comb begin
      for (int n = 0; n < N; n++) begin
         sum_s[n] = {SW{1'b0}};
         for (int m = 0; m < M; m++) begin
            if (del_spk_s[n][m]) begin
               sum_s[n] = sum_s[n] + SW'(w_s[n][m]);
            end else begin
               sum_s[n] = sum_s[n];
            end
         end
      end
   end

   // Neuron update: refractory hold, otherwise integrate, clamp, fire or leak.
   always_comb begin
      for (int n = 0; n < N; n++) begin
         v_s[n] = VW'(signed'({1'b0, mem_r[n]})) + VW'(sum_s[n]);
         if (v_s[n] < V_ZERO) begin
            vsat_s[n] = {MPW{1'b0}};
         end else if (v_s[n] > V_MAX) begin
            vsat_s[n] = {MPW{1'b1}};
         end else begin
            vsat_s[n] = v_s[n][MPW-1:0];
         end

         if (refr_r[n] != {MPW{1'b0}}) begin
            refr_nxt_s[n] = refr_r[n] - MPW'(1'b1);
            mem_nxt_s[n]  = {MPW{1'b0}};
            spk_nxt_s[n]  = 1'b0;
         end else if (vsat_s[n] >= threshold) begin
            refr_nxt_s[n] = refractory_period;
            mem_nxt_s[n]  = {MPW{1'b0}};
            spk_nxt_s[n]  = 1'b1;
         end else begin
            refr_nxt_s[n] = {MPW{1'b0}};
            spk_nxt_s[n]  = 1'b0;
            if (vsat_s[n] > decay) begin
               mem_nxt_s[n] = vsat_s[n] - decay;
            end else begin
               mem_nxt_s[n] = {MPW{1'b0}};
            end
         end
      end
   end

   // State registers: advance only on a timestep, otherwise hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int m = 0; m < M; m++) hist_r[m] <= {D{1'b0}};
         for (int n = 0; n < N; n++) begin
            mem_r[n]  <= {MPW{1'b0}};
            refr_r[n] <= {MPW{1'b0}};
         end
         spk_r  <= {N{1'b0}};
         done_r <= 1'b0;
      end else begin
         done_r <= timestep_s;
         if (timestep_s) begin
            for (int m = 0; m < M; m++) hist_r[m] <= {hist_r[m][D-2:0], input_spikes[m]};
            for (int n = 0; n < N; n++) begin
               mem_r[n]  <= mem_nxt_s[n];
               refr_r[n] <= refr_nxt_s[n];
            end
            spk_r <= spk_nxt_s;
         end
      end
   end

   assign output_spikes = spk_r;
   assign step_done     = done_r;

`ifdef SNN_MEMBRANE_OUT_EN
   for (genvar gn = 0; gn < N; gn++) begin : g_mem_out
      assign membrane_potential_out[gn*MPW +: MPW] = mem_r[gn];
   end
`else
   assign membrane_potential_out = {(N*MPW){1'b0}};
`endif

endmodule

// File: tb/tb_snn_delay_layer.sv
// -----------------------------------------------------------------------------
// tb_snn_delay_layer
//
// Self-checking bench for snn_delay_layer with default parameters.  A
// behavioural model keeps the past input vectors in a queue and the neuron
// state as plain integers, and is advanced once per timestep.  Directed
// scenarios use explicit expected spike patterns; a randomized run compares
// every cycle against the model.
// -----------------------------------------------------------------------------
module tb_snn_delay_layer;

   localparam int M = 24, N = 8, WW = 2, MPW = 6, DW = 3, D = 7;
   localparam logic [M-1:0] IN_M0   = 24'h000001;
   localparam logic [M-1:0] IN_NEG  = 24'h00000E;
   localparam logic [M-1:0] IN_ALL  = 24'hFFFFFF;
   localparam logic [M-1:0] IN_NONE = 24'h000000;
   localparam logic [M-1:0] IN_M012 = 24'h000007;

   logic               clk;
   logic               reset_n;
   logic               enable;
   logic               step;
   logic [M-1:0]       input_spikes;
   logic [N*M*WW-1:0]  weights;
   logic [N*M*DW-1:0]  delays;
   logic [MPW-1:0]     threshold;
   logic [MPW-1:0]     decay;
   logic [MPW-1:0]     refractory_period;
   logic [N-1:0]       output_spikes;
   logic               step_done;
   logic [N*MPW-1:0]   membrane_potential_out;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            mem_m  [N];
   int            refr_m [N];
   logic [N-1:0]  spk_m;
   logic [M-1:0]  past_q [$];

   snn_delay_layer #(.M(M), .N(N), .WW(WW), .MPW(MPW), .DW(DW)) dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .enable                 (enable),
      .step                   (step),
      .input_spikes           (input_spikes),
      .weights                (weights),
      .delays                 (delays),
      .threshold              (threshold),
      .decay                  (decay),
      .refractory_period      (refractory_period),
      .output_spikes          (output_spikes),
      .step_done              (step_done),
      .membrane_potential_out (membrane_potential_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      for (int n = 0; n < N; n++) begin
         mem_m[n]  = 0;
         refr_m[n] = 0;
      end
      spk_m = '0;
      past_q.delete();
   endtask

   task automatic model_step(input logic [M-1:0] in);
      int sum, v, d;
      logic signed [WW-1:0] w;
      logic s;
      for (int n = 0; n < N; n++) begin
         if (refr_m[n] > 0) begin
            refr_m[n] = refr_m[n] - 1;
            mem_m[n]  = 0;
            spk_m[n]  = 1'b0;
         end else begin
            sum = 0;
            for (int m = 0; m < M; m++) begin
               d = int'(delays[(n*M+m)*DW +: DW]);
               w = weights[(n*M+m)*WW +: WW];
               if (d == 0) s = in[m];
               else if (past_q.size() >= d) s = past_q[d-1][m];
               else s = 1'b0;
               if (s) sum += int'(w);
            end
            v = mem_m[n] + sum;
            if (v < 0) v = 0;
            if (v > (1 << MPW) - 1) v = (1 << MPW) - 1;
            if (v >= int'(threshold)) begin
               spk_m[n]  = 1'b1;
               mem_m[n]  = 0;
               refr_m[n] = int'(refractory_period);
            end else begin
               spk_m[n] = 1'b0;
               mem_m[n] = (v > int'(decay)) ? v - int'(decay) : 0;
            end
         end
      end
      past_q.push_front(in);
      if (past_q.size() > D) void'(past_q.pop_back());
   endtask

   function automatic logic [N*MPW-1:0] mem_vec();
      logic [N*MPW-1:0] r;
      r = '0;
`ifdef SNN_MEMBRANE_OUT_EN
      for (int n = 0; n < N; n++) r[n*MPW +: MPW] = mem_m[n][MPW-1:0];
`endif
      return r;
   endfunction

   task automatic clear_cfg();
      weights           = '0;
      delays            = '0;
      threshold         = 6'd0;
      decay             = 6'd0;
      refractory_period = 6'd0;
   endtask

   task automatic set_syn(input int n, input int m, input logic [WW-1:0] w, input logic [DW-1:0] d);
      weights[(n*M+m)*WW +: WW] = w;
      delays[(n*M+m)*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      enable  = 1'b0;
      step    = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // One timestep; the model advances with the values the DUT sampled.
   task automatic drive_step(input logic [M-1:0] in);
      @(negedge clk);
      input_spikes = in;
      enable       = 1'b1;
      step         = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      model_step(in);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      step = 1'b0;
      input_spikes = '0;
      clear_cfg();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (output_spikes !== 8'h00) begin
         errors++;
         $display("FAIL reset_spikes: got %h expected 00", output_spikes);
      end
      checks++;
      if (step_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %b expected 0", step_done);
      end
      checks++;
      if (membrane_potential_out !== 48'h0) begin
         errors++;
         $display("FAIL reset_membrane: got %h expected 0", membrane_potential_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_delay();
      logic [N-1:0] exp_spk;
      do_reset();
      clear_cfg();
      set_syn(0, 0, 2'b01, 3'd3);
      threshold = 6'd1;
      for (int i = 0; i < 6; i++) begin
         drive_step(i == 0 ? IN_M0 : IN_NONE);
         exp_spk = (i == 3) ? 8'h01 : 8'h00;
         checks++;
         if (output_spikes !== exp_spk) begin
            errors++;
            $display("FAIL delay3 step %0d: spikes %h expected %h", i, output_spikes, exp_spk);
         end
         checks++;
         if (step_done !== 1'b1) begin
            errors++;
            $display("FAIL delay3_done step %0d: got %b expected 1", i, step_done);
         end
      end
   endtask

   task automatic test_saturate();
      logic [N-1:0] exp_spk;
      do_reset();
      clear_cfg();
      for (int m = 0; m < M; m++) set_syn(0, m, 2'b01, 3'd0);
      threshold = 6'd63;
      for (int i = 0; i < 4; i++) begin
         drive_step(IN_ALL);
         exp_spk = (i == 2) ? 8'h01 : 8'h00;
         checks++;
         if (output_spikes !== exp_spk) begin
            errors++;
            $display("FAIL saturate step %0d: spikes %h expected %h", i, output_spikes, exp_spk);
         end
         checks++;
         if (membrane_potential_out !== mem_vec()) begin
            errors++;
            $display("FAIL saturate_mem step %0d: got %h expected %h", i, membrane_potential_out, mem_vec());
         end
      end
   endtask

   task automatic test_negative();
      logic [M-1:0] seq [6];
      logic [N-1:0] exp_spk;
      seq = '{IN_M0, IN_M0, IN_NEG, IN_M0, IN_M0, IN_M0};
      do_reset();
      clear_cfg();
      set_syn(0, 0, 2'b01, 3'd0);
      for (int m = 1; m < 4; m++) set_syn(0, m, 2'b11, 3'd0);
      threshold = 6'd3;
      for (int i = 0; i < 6; i++) begin
         drive_step(seq[i]);
         exp_spk = (i == 5) ? 8'h01 : 8'h00;
         checks++;
         if (output_spikes !== exp_spk) begin
            errors++;
            $display("FAIL negative_clamp step %0d: spikes %h expected %h", i, output_spikes, exp_spk);
         end
      end
   endtask

   task automatic test_refractory();
      logic [N-1:0] exp_spk;
      do_reset();
      clear_cfg();
      set_syn(0, 0, 2'b01, 3'd0);
      threshold = 6'd1;
      refractory_period = 6'd2;
      for (int i = 0; i < 7; i++) begin
         drive_step(IN_M0);
         exp_spk = (i % 3 == 0) ? 8'h01 : 8'h00;
         checks++;
         if (output_spikes !== exp_spk) begin
            errors++;
            $display("FAIL refractory step %0d: spikes %h expected %h", i, output_spikes, exp_spk);
         end
      end
   endtask

   task automatic test_decay();
      do_reset();
      clear_cfg();
      for (int m = 0; m < 3; m++) set_syn(0, m, 2'b01, 3'd0);
      threshold = 6'd4;
      decay = 6'd5;
      for (int i = 0; i < 3; i++) begin
         drive_step(IN_M012);
         checks++;
         if (output_spikes !== 8'h00) begin
            errors++;
            $display("FAIL decay step %0d: spikes %h expected 00", i, output_spikes);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      clear_cfg();
      set_syn(0, 0, 2'b01, 3'd0);
      threshold = 6'd2;
      drive_step(IN_M0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         enable = 1'b0;
         step = 1'b1;
         input_spikes = IN_ALL;
         threshold = 6'd0;
         @(posedge clk);
         #1;
         checks++;
         if (output_spikes !== 8'h00 || step_done !== 1'b0) begin
            errors++;
            $display("FAIL hold cycle %0d: spikes %h done %b expected 00 0", i, output_spikes, step_done);
         end
      end
      threshold = 6'd2;
      drive_step(IN_M0);
      checks++;
      if (output_spikes !== 8'h01) begin
         errors++;
         $display("FAIL hold_resume: spikes %h expected 01", output_spikes);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] exp_spk;
      do_reset();
      clear_cfg();
      set_syn(0, 0, 2'b01, 3'd7);
      threshold = 6'd1;
      for (int i = 0; i < 9; i++) begin
         drive_step(IN_M0);
         checks++;
         if (output_spikes !== spk_m) begin
            errors++;
            $display("FAIL prefill step %0d: spikes %h expected %h", i, output_spikes, spk_m);
         end
      end
      @(negedge clk);
      input_spikes = IN_M0;
      enable = 1'b1;
      step = 1'b1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (output_spikes !== 8'h00 || step_done !== 1'b0 || membrane_potential_out !== 48'h0) begin
         errors++;
         $display("FAIL async_reset: spikes %h done %b mem %h expected all 0", output_spikes, step_done, membrane_potential_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (output_spikes !== 8'h00 || step_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_step_discard: spikes %h done %b expected 00 0", output_spikes, step_done);
      end
      @(negedge clk);
      step = 1'b0;
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         drive_step(IN_M0);
         exp_spk = (i == 7) ? 8'h01 : 8'h00;
         checks++;
         if (output_spikes !== exp_spk) begin
            errors++;
            $display("FAIL post_reset_delay7 step %0d: spikes %h expected %h", i, output_spikes, exp_spk);
         end
      end
   endtask

   task automatic test_random();
      logic [MPW-1:0] thr_v, dec_v, ref_v;
      logic [N*M*WW-1:0] w_save;
      logic [N*M*DW-1:0] d_save;
      int idle, mode;
      do_reset();
      clear_cfg();
      for (int i = 0; i < 300; i++) begin
         if (i % 25 == 0) begin
            for (int b = 0; b < N*M*WW; b++) weights[b] = 1'($urandom);
            for (int b = 0; b < N*M*DW; b++) delays[b] = 1'($urandom);
         end
         thr_v = 6'($urandom_range(12, 0));
         dec_v = 6'($urandom_range(3, 0));
         ref_v = 6'($urandom_range(3, 0));
         w_save = weights;
         d_save = delays;
         idle = $urandom_range(2, 0);
         for (int k = 0; k < idle; k++) begin
            mode = $urandom_range(2, 0);
            @(negedge clk);
            enable = (mode == 1);
            step = (mode == 0);
            input_spikes = 24'($urandom);
            threshold = 6'($urandom);
            decay = 6'($urandom);
            refractory_period = 6'($urandom);
            for (int b = 0; b < N*M*WW; b++) weights[b] = 1'($urandom);
            for (int b = 0; b < N*M*DW; b++) delays[b] = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (output_spikes !== spk_m || step_done !== 1'b0 || membrane_potential_out !== mem_vec()) begin
               errors++;
               $display("FAIL rand_idle iter %0d: spikes %h done %b mem %h expected %h 0 %h",
                        i, output_spikes, step_done, membrane_potential_out, spk_m, mem_vec());
            end
         end
         weights = w_save;
         delays = d_save;
         threshold = thr_v;
         decay = dec_v;
         refractory_period = ref_v;
         drive_step(24'($urandom & $urandom));
         checks++;
         if (output_spikes !== spk_m) begin
            errors++;
            $display("FAIL rand_spikes iter %0d: got %h expected %h", i, output_spikes, spk_m);
         end
         checks++;
         if (step_done !== 1'b1) begin
            errors++;
            $display("FAIL rand_done iter %0d: got %b expected 1", i, step_done);
         end
         checks++;
         if (membrane_potential_out !== mem_vec()) begin
            errors++;
            $display("FAIL rand_mem iter %0d: got %h expected %h", i, membrane_potential_out, mem_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_delay();
      test_saturate();
      test_negative();
      test_refractory();
      test_decay();
      test_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snn_delay_layer.md
SNN_DELAY_LAYER -- requirements
Module: snn_delay_layer

Interface
REQ-001 SHALL have parameter M, default 24, number of input spike channels.
REQ-002 SHALL have parameter N, default 8, number of LIF neurons.
REQ-003 SHALL have parameter WW, default 2, weight width, two's complement.
REQ-004 SHALL have parameter MPW, default 6, membrane potential, threshold, decay and refractory width.
REQ-005 SHALL have parameter DW, default 3, delay field width; maximum delay D = 2^DW-1 steps.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1, global enable.
REQ-009 SHALL have port step, input, 1, timestep strobe; a timestep occurs on any cycle with enable=1 and step=1.
REQ-010 SHALL have port input_spikes, input, M, spikes for the current timestep.
REQ-011 SHALL have port weights, input, N*M*WW, synapse (n,m) at bits [(n*M+m)*WW +: WW].
REQ-012 SHALL have port delays, input, N*M*DW, synapse (n,m) at bits [(n*M+m)*DW +: DW].
REQ-013 SHALL have ports threshold, decay, refractory_period, each input, MPW, shared by all neurons.
REQ-014 SHALL have port output_spikes, output, N, registered neuron spikes.
REQ-015 SHALL have port step_done, output, 1, one-cycle pulse on the cycle after each timestep.
REQ-016 SHALL have port membrane_potential_out, output, N*MPW, neuron n at [n*MPW +: MPW].

Function
REQ-017 SHALL keep per input m a history shift register of D bits; on each timestep, shift input_spikes[m] into bit 0, bit k moving to k+1.
REQ-018 SHALL select the delayed spike for synapse (n,m) as input_spikes[m] when delay=0, else history bit delay-1 (spike from exactly `delay` timesteps earlier), sampled before the shift.
REQ-019 SHALL form the sum for neuron n as the signed sum of sign-extended weights of all synapses whose delayed spike is 1, at width WW+clog2(M)+1 with no overflow.
REQ-020 SHALL, when the refractory counter of n is nonzero at a timestep: decrement it, force membrane potential to 0, force output_spikes[n]=0, ignore the sum.
REQ-021 SHALL otherwise compute v = membrane + sum, saturated to [0, 2^MPW-1].
REQ-022 SHALL, if v >= threshold: set output_spikes[n]=1, set membrane to 0, load refractory counter with refractory_period.
REQ-023 SHALL, if v < threshold: set output_spikes[n]=0 and membrane = v-decay if v > decay, else 0.
REQ-024 SHALL hold all state, output_spikes and membrane unchanged on cycles without a timestep, including when step=1 and enable=0.
REQ-025 SHALL present the results of a timestep on the next cycle (latency 1), with step_done=1 for exactly that cycle.
REQ-026 SHALL fire every non-refractory timestep when threshold=0; refractory_period=0 means no refractory steps.
REQ-027 SHALL sample threshold, decay, refractory_period, weights and delays only at timesteps; changes between timesteps have no effect.

Reset
REQ-028 SHALL, while reset_n=0, immediately clear all history registers, membranes, refractory counters, output_spikes and step_done to 0.
REQ-029 SHALL discard a timestep coinciding with reset assertion; the first timestep after release sees empty history.

Configuration
REQ-030 SHALL, with macro SNN_MEMBRANE_OUT_EN defined, drive membrane_potential_out with registered membrane potentials.
REQ-031 SHALL, without SNN_MEMBRANE_OUT_EN, tie membrane_potential_out to 0, port still present; spike behaviour identical.

Verification
REQ-032 SHALL cover: delay=3, weight=+1 on (0,0), threshold=1, decay=0, single spike on m=0 at step 0 -> output_spikes[0]=1 only after step 3, step_done with it.
REQ-033 SHALL cover: delay=0, weight=+1 on all 24 synapses of neuron 0, all inputs 1, threshold=63 -> membrane saturates at 63, neuron fires that step, membrane 0 after.
REQ-034 SHALL cover: weight=-1 (2'b11) spike, membrane=2, decay=0 -> membrane clamps to 0, never negative.
REQ-035 SHALL cover: refractory_period=2, neuron fires at step k with input held high -> output_spikes[0]=0 at steps k+1,k+2, fires again at k+3.
REQ-036 SHALL cover: decay=5, membrane after sum=3, below threshold -> membrane 0 next step.
REQ-037 SHALL cover: reset_n pulsed low mid-run with D=7 history full -> all outputs 0 immediately; delay=7 synapse fires no spike for 7 steps after release.
